execute_stage: RTL and testbench

- Execute (E) stage of the 5-stage RV32I pipeline, directly downstream of the decode stage.
- Consumes the decode stage's registered E-side outputs and performs operand forwarding, the ALU operation, and branch/jump resolution.
- Drives PCSrcE/PCTargetE combinationally back to fetch.
- Registers the results into the E→M pipeline register that feeds the memory stage.

---
 rtl/execute_stage.sv | 128 ++++++++++++
 tb/tb_execute_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution, E->M register.
// Optional macro EXE_FORWARD_EN enables the ForwardAE/ForwardBE muxes; default build reads RD1E/RD2E directly.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, alu_result_e;
  logic            zero_e;

  logic            reg_write_d, reg_write_q;
  logic            mem_write_d, mem_write_q;
  logic [1:0]      result_src_d, result_src_q;
  logic [XLEN-1:0] alu_result_d, alu_result_q;
  logic [XLEN-1:0] write_data_d, write_data_q;
  logic [4:0]      rd_d, rd_q;
  logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;

`ifdef EXE_FORWARD_EN
  always_comb begin
    src_a_e = RD1E;
    case (ForwardAE)
      2'b01:   src_a_e = ResultW;
      2'b10:   src_a_e = alu_result_q;
      default: src_a_e = RD1E;
    endcase
    write_data_e = RD2E;
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = alu_result_q;
      default: write_data_e = RD2E;
    endcase
  end
`else
  // Forwarding disabled: hazard ports stay on the boundary but are not consumed.
  logic unused_fwd;
  assign unused_fwd   = ^{ForwardAE, ForwardBE, ResultW};
  assign src_a_e      = RD1E;
  assign write_data_e = RD2E;
`endif

  always_comb begin
    src_b_e      = ALUSrcE ? ImmExtE : write_data_e;
    alu_result_e = '0;
    case (ALUControlE)
      3'b000: alu_result_e = src_a_e + src_b_e;
      3'b001: alu_result_e = src_a_e - src_b_e;
      3'b010: alu_result_e = src_a_e & src_b_e;
      3'b011: alu_result_e = src_a_e | src_b_e;
      3'b100: alu_result_e = src_a_e ^ src_b_e;
      3'b101: alu_result_e = {{(XLEN-1){1'b0}}, $signed(src_a_e) < $signed(src_b_e)};
      3'b110: alu_result_e = src_a_e << src_b_e[4:0];
      3'b111: alu_result_e = src_a_e >> src_b_e[4:0];
      default: alu_result_e = '0;
    endcase
    zero_e    = (alu_result_e == '0);
    PCTargetE = PCE + ImmExtE;
    PCSrcE    = JumpE | (BranchE & zero_e);
  end

  // Flush only kills the side-effecting controls; data fields load regardless.
  always_comb begin
    reg_write_d  = RegWriteE & ~FlushM;
    mem_write_d  = MemWriteE & ~FlushM;
    result_src_d = ResultSrcE;
    alu_result_d = alu_result_e;
    write_data_d = write_data_e;
    rd_d         = RdE;
    pc_plus4_d   = PCPlus4E;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign RdM        = rd_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed + randomized bench for execute_stage against a behavioural model of the E stage.
module tb_execute_stage;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        JumpE, BranchE, ALUSrcE, MemWriteE, RegWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        FlushM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_alu_m = 32'h0;

  execute_stage #(.XLEN(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .FlushM(FlushM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
`ifdef EXE_FORWARD_EN
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return exp_alu_m;
`endif
    return rd;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  task automatic clr_inputs();
    {JumpE, BranchE, ALUSrcE, MemWriteE, RegWriteE, FlushM} = '0;
    ResultSrcE = 0; ALUControlE = 0; RD1E = 0; RD2E = 0; ImmExtE = 0;
    RdE = 0; PCE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  // Inputs are applied 1 time unit after a rising edge; this checks E outputs late
  // in the cycle, clocks once, then checks the M register.
  task automatic step(input string tag);
    logic [31:0] a, wd, b, res;
    logic        psrc;
    a    = fwd(ForwardAE, RD1E);
    wd   = fwd(ForwardBE, RD2E);
    b    = ALUSrcE ? ImmExtE : wd;
    res  = alu(ALUControlE, a, b);
    psrc = JumpE | (BranchE & (res == 0));
    #3;
    check({tag, ".PCSrcE"},    {31'd0, PCSrcE}, {31'd0, psrc});
    check({tag, ".PCTargetE"}, PCTargetE, PCE + ImmExtE);
    @(posedge CLK); #1;
    check({tag, ".RegWriteM"},  {31'd0, RegWriteM}, {31'd0, RegWriteE & !FlushM});
    check({tag, ".MemWriteM"},  {31'd0, MemWriteM}, {31'd0, MemWriteE & !FlushM});
    check({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, ResultSrcE});
    check({tag, ".ALUResultM"}, ALUResultM, res);
    check({tag, ".WriteDataM"}, WriteDataM, wd);
    check({tag, ".RdM"},        {27'd0, RdM}, {27'd0, RdE});
    check({tag, ".PCPlus4M"},   PCPlus4M, PCPlus4E);
    exp_alu_m = res;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, ".RegWriteM"},  {31'd0, RegWriteM}, 32'd0);
    check({tag, ".MemWriteM"},  {31'd0, MemWriteM}, 32'd0);
    check({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, 32'd0);
    check({tag, ".ALUResultM"}, ALUResultM, 32'd0);
    check({tag, ".WriteDataM"}, WriteDataM, 32'd0);
    check({tag, ".RdM"},        {27'd0, RdM}, 32'd0);
    check({tag, ".PCPlus4M"},   PCPlus4M, 32'd0);
  endtask

  initial begin
    clr_inputs();
    RESET_N = 1'b0;
    #1 check_m_zero("reset");
    #12 RESET_N = 1'b1;
    @(posedge CLK); #1;

    // add with immediate: 5 + 7
    clr_inputs(); RD1E = 5; ImmExtE = 7; ALUSrcE = 1; RdE = 3; RegWriteE = 1; PCPlus4E = 32'h14;
    step("addi");
    check("addi.value", ALUResultM, 32'd12);

    // slt: -1 < 1
    clr_inputs(); RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUControlE = 3'd5;
    step("slt");
    check("slt.value", ALUResultM, 32'd1);

    // sll uses only the low 5 bits of the shift amount
    clr_inputs(); RD1E = 1; RD2E = 32'h21; ALUControlE = 3'd6;
    step("sll");
    check("sll.value", ALUResultM, 32'd2);

    // taken branch with negative offset, then not-taken
    clr_inputs(); BranchE = 1; ALUControlE = 3'd1; RD1E = 9; RD2E = 9; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    #3 check("beq_taken.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    check("beq_taken.PCTargetE", PCTargetE, 32'hF0);
    #1 step("beq_taken");
    clr_inputs(); BranchE = 1; ALUControlE = 3'd1; RD1E = 9; RD2E = 8; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    step("beq_not");

    // forwarding: seed ALUResultM = 0x20, then forward it and ResultW
    clr_inputs(); RD1E = 32'h20; ALUSrcE = 1;
    step("fwd_seed");
    clr_inputs(); RD1E = 32'h11; RD2E = 32'h22; ResultW = 32'h30; ForwardAE = 2'b10; ForwardBE = 2'b01; MemWriteE = 1;
    step("fwd");
    clr_inputs(); RD1E = 32'h7; RD2E = 32'h3; ResultW = 32'h99; ForwardAE = 2'b11; ForwardBE = 2'b11;
    step("fwd11");

    // flush with jump: redirect still fires, M controls squashed
    clr_inputs(); FlushM = 1; RegWriteE = 1; MemWriteE = 1; JumpE = 1; PCE = 32'hFFFF_FFF0; ImmExtE = 32'h20;
    step("flush_jal");

    for (int i = 0; i < 60; i++) begin
      JumpE = ($urandom_range(0, 7) == 0); BranchE = $urandom_range(0, 1);
      ALUSrcE = $urandom_range(0, 1); MemWriteE = $urandom_range(0, 1); RegWriteE = $urandom_range(0, 1);
      ResultSrcE = 2'($urandom_range(0, 3)); ALUControlE = 3'($urandom_range(0, 7));
      RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
      ImmExtE = $urandom; RdE = 5'($urandom_range(0, 31)); PCE = $urandom; PCPlus4E = PCE + 4;
      ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3)); ResultW = $urandom;
      FlushM = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    // asynchronous reset mid-cycle after live traffic
    clr_inputs(); RD1E = 32'h1234; RD2E = 32'h55; RegWriteE = 1; MemWriteE = 1; RdE = 5'd9; ResultSrcE = 2'd2; PCPlus4E = 32'h40;
    step("pre_reset");
    #2 RESET_N = 1'b0;
    #1 check_m_zero("async_reset");
    @(posedge CLK); #1 check_m_zero("reset_held");
    #2 RESET_N = 1'b1;
    exp_alu_m = 32'h0;
    @(posedge CLK); #1;
    clr_inputs(); RD1E = 32'h8; RD2E = 32'h3; ALUControlE = 3'd7; RegWriteE = 1; RdE = 5'd4;
    step("post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
